fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It sits directly upstream of decode, where `ctrl_rom` turns the fetched word into a control word. It owns the PC, runs the single-outstanding-request handshake with the instruction cache, and absorbs decode stalls with a one-entry skid buffer. It also squashes wrong-path fetches on a redirect from execute.

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding I-cache
// request, absorbs decode stalls in a one-entry skid buffer, squashes wrong-path fetches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_read,
    output logic [31:0] icache_address,
    input  logic        icache_resp,
    input  logic [31:0] icache_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {RUN, DROP, HOLD} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [XLEN-1:0]   if_instr_q, if_instr_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]   skid_instr_q, skid_instr_d;

    // Request side: DROP must keep presenting the abandoned address until it completes.
    always_comb begin
        icache_read    = !rst && (state_q != HOLD);
        icache_address = (state_q == DROP) ? req_addr_q : pc_q;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        // Without a new word the output register drains to a bubble unless decode holds it.
        if (!stall) begin
            if_valid_d = 1'b0;
            if_pc_d    = '0;
            if_instr_d = '0;
        end

        unique case (state_q)
            RUN: begin
                req_addr_d = pc_q;
                if (redirect) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    if_pc_d    = '0;
                    if_instr_d = '0;
                    state_d    = icache_resp ? RUN : DROP;
                end else if (icache_resp) begin
                    pc_d = pc_q + XLEN'(4);
                    if (!stall || !if_valid_q) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = icache_rdata;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = icache_rdata;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    if_valid_d   = 1'b0;
                    if_pc_d      = '0;
                    if_instr_d   = '0;
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    state_d      = RUN;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = skid_pc_q;
                    if_instr_d = skid_instr_q;
                    state_d    = RUN;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    if_pc_d    = '0;
                    if_instr_d = '0;
                end
                // The stale word is discarded; pc already holds the newest target.
                if (icache_resp) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scenario tasks with inline hand-computed checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_read;
    logic [31:0] icache_address;
    logic        icache_resp;
    logic [31:0] icache_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        auto_hit;
    logic        man_resp;
    logic [31:0] man_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Same-cycle-hit cache returning the address as data, or manually driven response.
    assign icache_resp  = auto_hit ? icache_read : man_resp;
    assign icache_rdata = auto_hit ? icache_address : man_rdata;

    fetch_stage #(.RESET_PC(32'h0000_0060)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    // Advance one edge; inputs change 1ns after posedge, checks land well before the next one.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; auto_hit = 1'b1; man_resp = 1'b0; man_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        cyc(); cyc();
        #1;
        checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", icache_read); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", if_instr); end
    endtask

    task automatic test_free_run();
        rst = 1'b0;
        #1;
        checks++; if (icache_read !== 1'b1 || icache_address !== 32'h60) begin errors++; $display("FAIL run_req0 got %b/%h exp 1/00000060", icache_read, icache_address); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h60 || if_instr !== 32'h60) begin errors++; $display("FAIL run_out0 got %b/%h/%h exp 1/00000060/00000060", if_valid, if_pc, if_instr); end
        checks++; if (icache_address !== 32'h64) begin errors++; $display("FAIL run_req1 got %h exp 00000064", icache_address); end
        cyc(); #1;
        checks++; if (if_pc !== 32'h64 || if_instr !== 32'h64) begin errors++; $display("FAIL run_out1 got %h/%h exp 00000064/00000064", if_pc, if_instr); end
        checks++; if (icache_address !== 32'h68) begin errors++; $display("FAIL run_req2 got %h exp 00000068", icache_address); end
    endtask

    task automatic test_stall_skid();
        stall = 1'b1;
        cyc(); #1;
        checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL hold_read1 got %b exp 0", icache_read); end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h64) begin errors++; $display("FAIL hold_out1 got %b/%h exp 1/00000064", if_valid, if_pc); end
        cyc(); #1;
        checks++; if (icache_read !== 1'b0 || if_pc !== 32'h64) begin errors++; $display("FAIL hold_2 got %b/%h exp 0/00000064", icache_read, if_pc); end
        stall = 1'b0;
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h68 || if_instr !== 32'h68) begin errors++; $display("FAIL skid_out got %b/%h/%h exp 1/00000068/00000068", if_valid, if_pc, if_instr); end
        checks++; if (icache_read !== 1'b1 || icache_address !== 32'h6C) begin errors++; $display("FAIL skid_next got %b/%h exp 1/0000006c", icache_read, icache_address); end
    endtask

    task automatic test_redirect_hold();
        stall = 1'b1;
        cyc(); #1;
        checks++; if (icache_read !== 1'b0 || if_pc !== 32'h68) begin errors++; $display("FAIL rh_hold got %b/%h exp 0/00000068", icache_read, if_pc); end
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect = 1'b0; stall = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin errors++; $display("FAIL rh_bubble got %b/%h exp 0/00000000", if_valid, if_instr); end
        checks++; if (icache_read !== 1'b1 || icache_address !== 32'h200) begin errors++; $display("FAIL rh_req got %b/%h exp 1/00000200", icache_read, icache_address); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL rh_out got %b/%h exp 1/00000200", if_valid, if_pc); end
    endtask

    task automatic test_redirect_resp();
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (icache_address !== 32'h204 || icache_resp !== 1'b1) begin errors++; $display("FAIL rr_pre got %h/%b exp 00000204/1", icache_address, icache_resp); end
        cyc();
        redirect_pc = 32'h80;
        #1;
        checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0) begin errors++; $display("FAIL rr_squash got %b/%h exp 0/00000000", if_valid, if_pc); end
        checks++; if (icache_read !== 1'b1 || icache_address !== 32'h100) begin errors++; $display("FAIL rr_req got %b/%h exp 1/00000100", icache_read, icache_address); end
        cyc();
        redirect = 1'b0; auto_hit = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || icache_address !== 32'h80) begin errors++; $display("FAIL rr_req2 got %b/%h exp 0/00000080", if_valid, icache_address); end
    endtask

    task automatic test_redirect_miss();
        cyc();
        redirect = 1'b1; redirect_pc = 32'h400;
        #1;
        checks++; if (icache_address !== 32'h80 || if_valid !== 1'b0) begin errors++; $display("FAIL rm_c2 got %h/%b exp 00000080/0", icache_address, if_valid); end
        cyc();
        redirect = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            if (i == 5) begin man_resp = 1'b1; man_rdata = 32'hDEAD_BEEF; end
            #1;
            checks++; if (icache_read !== 1'b1 || icache_address !== 32'h80 || if_valid !== 1'b0) begin errors++; $display("FAIL rm_drop%0d got %b/%h/%b exp 1/00000080/0", i, icache_read, icache_address, if_valid); end
            cyc();
        end
        man_resp = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin errors++; $display("FAIL rm_discard got %b/%h exp 0/00000000", if_valid, if_instr); end
        checks++; if (icache_read !== 1'b1 || icache_address !== 32'h400) begin errors++; $display("FAIL rm_next got %b/%h exp 1/00000400", icache_read, icache_address); end
    endtask

    task automatic test_reset_drop();
        redirect = 1'b1; redirect_pc = 32'h500;
        cyc();
        redirect = 1'b0;
        #1;
        checks++; if (icache_address !== 32'h400 || icache_read !== 1'b1) begin errors++; $display("FAIL rd_drop got %h/%b exp 00000400/1", icache_address, icache_read); end
        rst = 1'b1;
        #1;
        checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL rd_read got %b exp 0", icache_read); end
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %b exp 0", if_valid); end
        checks++; if (icache_read !== 1'b1 || icache_address !== 32'h60) begin errors++; $display("FAIL rd_pc got %b/%h exp 1/00000060", icache_read, icache_address); end
        man_resp = 1'b1; man_rdata = 32'h1234_5678;
        cyc();
        man_resp = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h60 || if_instr !== 32'h1234_5678) begin errors++; $display("FAIL rd_run got %b/%h/%h exp 1/00000060/12345678", if_valid, if_pc, if_instr); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall_skid();
        test_redirect_hold();
        test_redirect_resp();
        test_redirect_miss();
        test_reset_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
